exception_sequencer: RTL and testbench

- Sequences exception entry and exit around the CP0 status/cause/EPC block.
- Latches exception requests from the pipeline and prioritises them.
- Stalls and drains the pipeline, then pulses cause_write with the 3-bit cause code.
- Redirects fetch to the kernel handler vector; on return-from-exception it pulses exit_kernel and redirects fetch to EPC.
- Sits between the hazard unit, fetch PC mux and CP0.

---
 rtl/cpu_exc_pkg.sv | 32 +++
 rtl/exc_pending_prio.sv | 54 +++++
 rtl/exception_sequencer.sv | 139 +++++++++++++
 tb/tb_exception_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_exc_pkg.sv
// Shared types and constants for the exception entry/exit sequencer.
// Cause codes match the encoding CP0 expects on int_cause.
package cpu_exc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    ENTER  = 3'd2,
    KERNEL = 3'd3,
    EXIT   = 3'd4
  } exc_state_e;

  localparam logic [2:0] CAUSE_NONE    = 3'b000;
  localparam logic [2:0] CAUSE_PFAULT  = 3'b001;
  localparam logic [2:0] CAUSE_SYSCALL = 3'b010;
  localparam logic [2:0] CAUSE_IRQ     = 3'b011;

  localparam logic [31:0] HANDLER_VEC_DEFAULT = 32'h0000_0180;

  // Number of sticky pulse sources; index 0 outranks index 1.
  localparam int NUM_PULSE_SRC = 2;

  function automatic logic [2:0] pulse_src_code(input int idx);
    return (idx == 0) ? CAUSE_PFAULT : CAUSE_SYSCALL;
  endfunction

  // Drain counter must hold 0..DRAIN_CYCLES-1 and never be zero width.
  function automatic int drain_cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/exc_pending_prio.sv
// Sticky request latches for pulse sources plus a fixed-priority encoder.
// A new pulse always wins over a same-cycle clear, so no request is dropped.
module exc_pending_prio
  import cpu_exc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       page_fault,
  input  logic       syscall,
  input  logic       irq_ext,
  input  logic       clear_en,
  input  logic [2:0] clear_code,
  output logic       any_req,
  output logic [2:0] code
);

  logic [NUM_PULSE_SRC-1:0] pulse;
  logic [NUM_PULSE_SRC-1:0] pend_reg;
  logic [NUM_PULSE_SRC-1:0] pend_next;
  logic [NUM_PULSE_SRC-1:0] clr;
  logic [NUM_PULSE_SRC-1:0] req;

  assign pulse = {syscall, page_fault};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PULSE_SRC; gi++) begin : g_src
      assign clr[gi]       = clear_en && (clear_code == pulse_src_code(gi));
      assign pend_next[gi] = (pend_reg[gi] & ~clr[gi]) | pulse[gi];
      assign req[gi]       = pend_reg[gi] | pulse[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pend_reg[gi] <= 1'b0;
        end else begin
          pend_reg[gi] <= pend_next[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    any_req = (|req) | irq_ext;
    code    = CAUSE_NONE;
    if (req[0]) begin
      code = CAUSE_PFAULT;
    end else if (req[1]) begin
      code = CAUSE_SYSCALL;
    end else if (irq_ext) begin
      code = CAUSE_IRQ;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Exception entry/exit sequencer: drain, enter handler, wait for eret, return to EPC.
// All outputs decode from the current state only.
module exception_sequencer
  import cpu_exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_VEC  = HANDLER_VEC_DEFAULT,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        page_faultM,
  input  logic        syscallD,
  input  logic        irq_ext,
  input  logic        eretD,
  input  logic        kernel_mode,
  input  logic [31:0] epc,
  output logic        stall_pipe,
  output logic        flush_pipe,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        cause_write,
  output logic [2:0]  int_cause,
  output logic        exit_kernel,
  output logic        busy
);

  localparam int CNT_W        = drain_cnt_width(DRAIN_CYCLES);
  localparam int DRAIN_LAST_I = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LAST_I);

  exc_state_e       state_reg;
  exc_state_e       state_next;
  logic [2:0]       cause_sel_reg;
  logic [2:0]       cause_sel_next;
  logic [CNT_W-1:0] drain_cnt_reg;
  logic [CNT_W-1:0] drain_cnt_next;

  logic       any_req;
  logic [2:0] req_code;
  logic       take_req;
  logic       drain_done;

  exc_pending_prio u_pending (
    .clk        (clk),
    .reset      (reset),
    .page_fault (page_faultM),
    .syscall    (syscallD),
    .irq_ext    (irq_ext),
    .clear_en   (state_reg == ENTER),
    .clear_code (cause_sel_reg),
    .any_req    (any_req),
    .code       (req_code)
  );

  // kernel_mode reads 1 while the CPU runs user code.
  assign take_req   = (state_reg == IDLE) && any_req && kernel_mode;
  assign drain_done = (drain_cnt_reg == DRAIN_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cause_sel_reg <= CAUSE_NONE;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cause_sel_reg <= cause_sel_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cause_sel_next = cause_sel_reg;
    drain_cnt_next = '0;
    case (state_reg)
      IDLE: begin
        if (take_req) begin
          cause_sel_next = req_code;
          state_next     = (DRAIN_CYCLES == 0) ? ENTER : DRAIN;
        end
      end
      DRAIN: begin
        // Saturate rather than wrap; the exit compare is an equality.
        if (drain_done) begin
          drain_cnt_next = drain_cnt_reg;
          state_next     = ENTER;
        end else begin
          drain_cnt_next = drain_cnt_reg + CNT_W'(1);
        end
      end
      ENTER: begin
        state_next = KERNEL;
      end
      KERNEL: begin
        if (eretD) begin
          state_next = EXIT;
        end
      end
      EXIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    stall_pipe  = 1'b0;
    flush_pipe  = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 32'h0000_0000;
    cause_write = 1'b0;
    int_cause   = CAUSE_NONE;
    exit_kernel = 1'b0;
    busy        = (state_reg != IDLE);
    case (state_reg)
      DRAIN: begin
        stall_pipe = 1'b1;
      end
      ENTER: begin
        cause_write = 1'b1;
        int_cause   = cause_sel_reg;
        flush_pipe  = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = HANDLER_VEC;
      end
      EXIT: begin
        exit_kernel = 1'b1;
        flush_pipe  = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = epc;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer with a scoreboard of expected entry/exit events.
// A small CP0 model flips kernel_mode on cause_write and exit_kernel.
module tb_exception_sequencer;

  localparam logic [31:0] HVEC = 32'h0000_0180;

  logic        clk;
  logic        reset;
  logic        page_faultM;
  logic        syscallD;
  logic        irq_ext;
  logic        eretD;
  logic        kernel_mode;
  logic [31:0] epc;
  logic        stall_pipe;
  logic        flush_pipe;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        cause_write;
  logic [2:0]  int_cause;
  logic        exit_kernel;
  logic        busy;

  logic        irq0;
  logic        stall0;
  logic        flush0;
  logic        redir0;
  logic [31:0] target0;
  logic        cw0;
  logic [2:0]  cause0;
  logic        exit0;
  logic        busy0;

  exception_sequencer #(.HANDLER_VEC(HVEC), .DRAIN_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .page_faultM (page_faultM),
    .syscallD    (syscallD),
    .irq_ext     (irq_ext),
    .eretD       (eretD),
    .kernel_mode (kernel_mode),
    .epc         (epc),
    .stall_pipe  (stall_pipe),
    .flush_pipe  (flush_pipe),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target),
    .cause_write (cause_write),
    .int_cause   (int_cause),
    .exit_kernel (exit_kernel),
    .busy        (busy)
  );

  exception_sequencer #(.HANDLER_VEC(HVEC), .DRAIN_CYCLES(0)) dut0 (
    .clk         (clk),
    .reset       (reset),
    .page_faultM (1'b0),
    .syscallD    (1'b0),
    .irq_ext     (irq0),
    .eretD       (1'b0),
    .kernel_mode (1'b1),
    .epc         (32'h0000_0000),
    .stall_pipe  (stall0),
    .flush_pipe  (flush0),
    .pc_redirect (redir0),
    .pc_target   (target0),
    .cause_write (cw0),
    .int_cause   (cause0),
    .exit_kernel (exit0),
    .busy        (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [2:0]  code;
    logic [31:0] tgt;
  } exp_t;

  exp_t cause_q[$];
  exp_t exit_q[$];

  int   nchk;
  int   npass;
  int   nfail;
  int   cyc;
  logic km_next;
  logic stall0_seen;

  logic        s_stall, s_flush, s_redir, s_cw, s_exit, s_busy;
  logic [31:0] s_target;
  logic [2:0]  s_cause;
  logic        s0_cw;
  logic [2:0]  s0_cause;
  logic [31:0] s0_target;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_cause(input int at, input logic [2:0] code);
    exp_t e;
    e.cyc = at; e.code = code; e.tgt = HVEC;
    cause_q.push_back(e);
  endtask

  task automatic push_exit(input int at, input logic [31:0] tgt);
    exp_t e;
    e.cyc = at; e.code = 3'b000; e.tgt = tgt;
    exit_q.push_back(e);
  endtask

  // One cycle: sample at negedge, score events, advance past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    s_stall = stall_pipe; s_flush = flush_pipe; s_redir = pc_redirect;
    s_cw = cause_write; s_exit = exit_kernel; s_busy = busy;
    s_target = pc_target; s_cause = int_cause;
    s0_cw = cw0; s0_cause = cause0; s0_target = target0;
    if (stall0) stall0_seen = 1'b1;
    if (s_cw) begin
      if (cause_q.size() == 0) begin
        chk("unexpected_cause_write", 32'(s_cw), 32'd0);
      end else begin
        e = cause_q.pop_front();
        chk("enter_cycle", 32'(cyc), 32'(e.cyc));
        chk("int_cause", 32'(s_cause), 32'(e.code));
        chk("enter_target", s_target, e.tgt);
        chk("enter_flush_redirect", {30'd0, s_flush, s_redir}, 32'd3);
      end
      km_next = 1'b0;
    end else begin
      chk("int_cause_outside_enter", 32'(s_cause), 32'd0);
    end
    if (s_exit) begin
      if (exit_q.size() == 0) begin
        chk("unexpected_exit_kernel", 32'(s_exit), 32'd0);
      end else begin
        e = exit_q.pop_front();
        chk("exit_cycle", 32'(cyc), 32'(e.cyc));
        chk("exit_target", s_target, e.tgt);
        chk("exit_flush_redirect", {30'd0, s_flush, s_redir}, 32'd3);
      end
      km_next = 1'b1;
    end
    @(posedge clk);
    #1;
    page_faultM = 1'b0;
    syscallD    = 1'b0;
    eretD       = 1'b0;
    kernel_mode = km_next;
    cyc++;
  endtask

  initial begin
    nchk = 0; npass = 0; nfail = 0; cyc = 0;
    km_next = 1'b1; stall0_seen = 1'b0;
    reset = 1'b1; page_faultM = 1'b0; syscallD = 1'b0; irq_ext = 1'b0;
    eretD = 1'b0; kernel_mode = 1'b1; epc = 32'h0; irq0 = 1'b0;

    // Reset state
    step(); step();
    chk("reset_busy", 32'(s_busy), 32'd0);
    chk("reset_stall", 32'(s_stall), 32'd0);
    chk("reset_flush_redirect", {30'd0, s_flush, s_redir}, 32'd0);
    chk("reset_target", s_target, 32'd0);
    chk("reset_strobes", {30'd0, s_cw, s_exit}, 32'd0);
    reset = 1'b0;

    // Zero-drain build: irq level goes straight to ENTER next cycle
    irq0 = 1'b1;
    step();
    chk("d0_no_early_entry", 32'(s0_cw), 32'd0);
    step();
    chk("d0_cause_write", 32'(s0_cw), 32'd1);
    chk("d0_int_cause", 32'(s0_cause), 32'd3);
    chk("d0_target", s0_target, HVEC);
    irq0 = 1'b0;

    // Syscall entry with two drain cycles; page fault during DRAIN must not override
    syscallD = 1'b1;
    push_cause(cyc + 3, 3'b010);
    step();
    chk("c0_stall", 32'(s_stall), 32'd0);
    page_faultM = 1'b1;
    step();
    chk("drain1_stall", 32'(s_stall), 32'd1);
    chk("drain1_busy", 32'(s_busy), 32'd1);
    step();
    chk("drain2_stall", 32'(s_stall), 32'd1);
    step();
    chk("enter_no_stall", 32'(s_stall), 32'd0);
    step();
    chk("kernel_busy", 32'(s_busy), 32'd1);
    chk("kernel_no_flush", 32'(s_flush), 32'd0);

    // Return: EXIT redirects to EPC, then the latched page fault is taken
    epc = 32'h0040_0010;
    eretD = 1'b1;
    push_exit(cyc + 1, 32'h0040_0010);
    step();
    step();
    chk("exit_strobe", 32'(s_exit), 32'd1);
    epc = 32'hDEAD_0000;
    push_cause(cyc + 3, 3'b001);
    step();
    chk("idle_after_exit", 32'(s_busy), 32'd0);
    repeat (3) step();

    eretD = 1'b1;
    push_exit(cyc + 1, 32'hDEAD_0000);
    repeat (3) step();

    // Page fault and irq together: fault first, irq after the return
    page_faultM = 1'b1;
    irq_ext = 1'b1;
    push_cause(cyc + 3, 3'b001);
    repeat (4) step();
    repeat (2) step();
    chk("kernel_holds_irq", 32'(s_cw), 32'd0);
    epc = 32'h0040_0020;
    eretD = 1'b1;
    push_exit(cyc + 1, 32'h0040_0020);
    push_cause(cyc + 5, 3'b011);
    repeat (6) step();
    irq_ext = 1'b0;

    // Syscall while in kernel waits until after EXIT, then taken once
    syscallD = 1'b1;
    repeat (3) step();
    chk("kernel_syscall_deferred", 32'(s_cw), 32'd0);
    eretD = 1'b1;
    push_exit(cyc + 1, 32'h0040_0020);
    push_cause(cyc + 5, 3'b010);
    repeat (6) step();

    // eret and a new request in the same KERNEL cycle: eret wins
    page_faultM = 1'b1;
    eretD = 1'b1;
    push_exit(cyc + 1, 32'h0040_0020);
    push_cause(cyc + 5, 3'b001);
    repeat (6) step();
    eretD = 1'b1;
    push_exit(cyc + 1, 32'h0040_0020);
    repeat (3) step();
    repeat (5) step();
    chk("idle_no_repeat", 32'(s_busy), 32'd0);

    // Reset during DRAIN drops the request immediately
    syscallD = 1'b1;
    step();
    chk("pre_reset_drain", 32'(stall_pipe), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_mid_stall", 32'(stall_pipe), 32'd0);
    chk("reset_mid_busy", 32'(busy), 32'd0);
    chk("reset_mid_outputs", {29'd0, flush_pipe, pc_redirect, cause_write}, 32'd0);
    step();
    reset = 1'b0;
    repeat (6) step();
    chk("post_reset_idle", 32'(s_busy), 32'd0);

    chk("cause_events_left", 32'(cause_q.size()), 32'd0);
    chk("exit_events_left", 32'(exit_q.size()), 32'd0);
    chk("d0_stall_never", 32'(stall0_seen), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
